add_reservation_station: RTL and testbench

//  Tomasulo reservation station for the add functional unit. Sits directly downstream of the common data bus (CDB).

---
 rtl/add_reservation_station_pkg.sv | 47 ++++
 rtl/add_reservation_station_rs_entry.sv | 74 +++++++
 rtl/add_reservation_station.sv | 108 ++++++++++
 tb/tb_add_reservation_station.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/add_reservation_station_pkg.sv
// Shared types and constants for the add-unit reservation station.
// Operand snooping is a helper so issue bypass and CDB capture use the same compare.
package add_reservation_station_pkg;

    localparam int unsigned RS_DEPTH = 4;
    localparam int unsigned TAG_W    = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned OP_W     = 4;

    localparam logic [TAG_W-1:0] RS_TAG_BASE = 5'd1;
    localparam logic [TAG_W-1:0] INVALID_TAG = 5'b11111;

    typedef enum logic [1:0] {
        ST_FREE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2,
        ST_EXEC  = 2'd3
    } rs_state_e;

    typedef struct packed {
        logic [TAG_W-1:0]  q;
        logic [DATA_W-1:0] v;
    } rs_operand_t;

    typedef struct packed {
        logic [OP_W-1:0] op;
        rs_operand_t     j;
        rs_operand_t     k;
    } rs_issue_t;

    // Capture a CDB value into an operand still waiting on that tag.
    function automatic rs_operand_t snoop(
        input rs_operand_t       cur,
        input logic              bcast,
        input logic [TAG_W-1:0]  tag,
        input logic [DATA_W-1:0] val
    );
        rs_operand_t res;
        res = cur;
        if (bcast && (cur.q != INVALID_TAG) && (cur.q == tag)) begin
            res.q = INVALID_TAG;
            res.v = val;
        end
        return res;
    endfunction

endpackage

// File: rtl/add_reservation_station_rs_entry.sv
// One reservation-station entry: lifecycle FSM plus CDB snoop of its two operands.
// The entry stays occupied through execution until its own tag is broadcast.
module add_reservation_station_rs_entry
    import add_reservation_station_pkg::*;
#(
    parameter logic [TAG_W-1:0] OWN_TAG = RS_TAG_BASE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_we,
    input  rs_issue_t         issue,
    input  logic              dispatch_fire,
    input  logic              cdb_broadcast,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_val,
    output rs_state_e         state,
    output logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] vj,
    output logic [DATA_W-1:0] vk
);

    rs_operand_t opj, opk;
    rs_operand_t iss_j, iss_k, snp_j, snp_k;

    always_comb begin
        iss_j = snoop(issue.j, cdb_broadcast, cdb_tag, cdb_val);
        iss_k = snoop(issue.k, cdb_broadcast, cdb_tag, cdb_val);
        snp_j = snoop(opj, cdb_broadcast, cdb_tag, cdb_val);
        snp_k = snoop(opk, cdb_broadcast, cdb_tag, cdb_val);
    end

    assign vj = opj.v;
    assign vk = opk.v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_FREE;
            op    <= '0;
            opj   <= '{q: INVALID_TAG, v: '0};
            opk   <= '{q: INVALID_TAG, v: '0};
        end else begin
            case (state)
                ST_FREE: begin
                    if (issue_we) begin
                        op  <= issue.op;
                        opj <= iss_j;
                        opk <= iss_k;
                        state <= ((iss_j.q == INVALID_TAG) && (iss_k.q == INVALID_TAG))
                                 ? ST_READY : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    opj <= snp_j;
                    opk <= snp_k;
                    if ((snp_j.q == INVALID_TAG) && (snp_k.q == INVALID_TAG)) begin
                        state <= ST_READY;
                    end
                end
                ST_READY: begin
                    if (dispatch_fire) begin
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cdb_broadcast && (cdb_tag == OWN_TAG)) begin
                        state <= ST_FREE;
                    end
                end
                default: state <= ST_FREE;
            endcase
        end
    end

endmodule

// File: rtl/add_reservation_station.sv
// Reservation station for the add unit: issue into the lowest free entry,
// dispatch the lowest ready entry, entries snoop the CDB for operands and their own completion.
module add_reservation_station
    import add_reservation_station_pkg::*;
#(
    parameter int unsigned DEPTH = RS_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_issue_valid,
    input  logic [OP_W-1:0]   in_issue_op,
    input  logic [TAG_W-1:0]  in_issue_qj,
    input  logic [DATA_W-1:0] in_issue_vj,
    input  logic [TAG_W-1:0]  in_issue_qk,
    input  logic [DATA_W-1:0] in_issue_vk,
    output logic              out_issue_ready,
    output logic [TAG_W-1:0]  out_issue_tag,
    input  logic              in_cdb_broadcast,
    input  logic [TAG_W-1:0]  in_cdb_tag,
    input  logic [DATA_W-1:0] in_cdb_val,
    output logic              out_dispatch_valid,
    output logic [OP_W-1:0]   out_dispatch_op,
    output logic [DATA_W-1:0] out_dispatch_vj,
    output logic [DATA_W-1:0] out_dispatch_vk,
    output logic [TAG_W-1:0]  out_dispatch_tag,
    input  logic              in_fu_ready
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    rs_state_e         st   [DEPTH];
    logic [OP_W-1:0]   e_op [DEPTH];
    logic [DATA_W-1:0] e_vj [DEPTH];
    logic [DATA_W-1:0] e_vk [DEPTH];

    logic [DEPTH-1:0] issue_we;
    logic [DEPTH-1:0] dispatch_fire;
    rs_issue_t        issue;
    logic             free_found, rdy_found;
    logic [IDX_W-1:0] free_idx, rdy_idx;

    always_comb begin
        issue.op  = in_issue_op;
        issue.j.q = in_issue_qj;
        issue.j.v = in_issue_vj;
        issue.k.q = in_issue_qk;
        issue.k.v = in_issue_vk;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        assign issue_we[i]      = in_issue_valid && free_found && (free_idx == IDX_W'(i));
        assign dispatch_fire[i] = in_fu_ready && rdy_found && (rdy_idx == IDX_W'(i));

        add_reservation_station_rs_entry #(
            .OWN_TAG(TAG_W'(RS_TAG_BASE + i))
        ) u_entry (
            .clk           (clk),
            .rst           (rst),
            .issue_we      (issue_we[i]),
            .issue         (issue),
            .dispatch_fire (dispatch_fire[i]),
            .cdb_broadcast (in_cdb_broadcast),
            .cdb_tag       (in_cdb_tag),
            .cdb_val       (in_cdb_val),
            .state         (st[i]),
            .op            (e_op[i]),
            .vj            (e_vj[i]),
            .vk            (e_vk[i])
        );
    end

    // Descending scan so the lowest matching index wins.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        rdy_found  = 1'b0;
        rdy_idx    = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (st[i] == ST_FREE) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (st[i] == ST_READY) begin
                rdy_found = 1'b1;
                rdy_idx   = IDX_W'(i);
            end
        end
    end

    assign out_issue_ready = free_found;
    assign out_issue_tag   = free_found ? TAG_W'(RS_TAG_BASE + TAG_W'(free_idx)) : INVALID_TAG;

    always_comb begin
        out_dispatch_valid = 1'b0;
        out_dispatch_op    = '0;
        out_dispatch_vj    = '0;
        out_dispatch_vk    = '0;
        out_dispatch_tag   = '0;
        if (rdy_found) begin
            out_dispatch_valid = 1'b1;
            out_dispatch_op    = e_op[rdy_idx];
            out_dispatch_vj    = e_vj[rdy_idx];
            out_dispatch_vk    = e_vk[rdy_idx];
            out_dispatch_tag   = TAG_W'(RS_TAG_BASE + TAG_W'(rdy_idx));
        end
    end

endmodule

// File: tb/tb_add_reservation_station.sv
// Directed bench for add_reservation_station: a per-cycle vector table plus
// hand-written sequences for full-station and dispatch-stall behaviour.
module tb_add_reservation_station;

    localparam logic [4:0] I = 5'd31;

    typedef struct {
        logic        iv;
        logic [3:0]  op;
        logic [4:0]  qj;
        logic [31:0] vj;
        logic [4:0]  qk;
        logic [31:0] vk;
        logic        cb;
        logic [4:0]  ct;
        logic [31:0] cv;
        logic        fu;
        logic        e_ir;
        logic [4:0]  e_itag;
        logic        e_dv;
        logic [3:0]  e_op;
        logic [31:0] e_vj;
        logic [31:0] e_vk;
        logic [4:0]  e_tag;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_issue_valid = 1'b0;
    logic [3:0]  in_issue_op = '0;
    logic [4:0]  in_issue_qj = I;
    logic [31:0] in_issue_vj = '0;
    logic [4:0]  in_issue_qk = I;
    logic [31:0] in_issue_vk = '0;
    logic        in_cdb_broadcast = 1'b0;
    logic [4:0]  in_cdb_tag = '0;
    logic [31:0] in_cdb_val = '0;
    logic        in_fu_ready = 1'b0;
    logic        out_issue_ready;
    logic [4:0]  out_issue_tag;
    logic        out_dispatch_valid;
    logic [3:0]  out_dispatch_op;
    logic [31:0] out_dispatch_vj;
    logic [31:0] out_dispatch_vk;
    logic [4:0]  out_dispatch_tag;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    add_reservation_station dut (
        .clk                (clk),
        .rst                (rst),
        .in_issue_valid     (in_issue_valid),
        .in_issue_op        (in_issue_op),
        .in_issue_qj        (in_issue_qj),
        .in_issue_vj        (in_issue_vj),
        .in_issue_qk        (in_issue_qk),
        .in_issue_vk        (in_issue_vk),
        .out_issue_ready    (out_issue_ready),
        .out_issue_tag      (out_issue_tag),
        .in_cdb_broadcast   (in_cdb_broadcast),
        .in_cdb_tag         (in_cdb_tag),
        .in_cdb_val         (in_cdb_val),
        .out_dispatch_valid (out_dispatch_valid),
        .out_dispatch_op    (out_dispatch_op),
        .out_dispatch_vj    (out_dispatch_vj),
        .out_dispatch_vk    (out_dispatch_vk),
        .out_dispatch_tag   (out_dispatch_tag),
        .in_fu_ready        (in_fu_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t inp(input logic iv, input logic [3:0] op,
                                 input logic [4:0] qj, input logic [31:0] vj,
                                 input logic [4:0] qk, input logic [31:0] vk,
                                 input logic cb, input logic [4:0] ct,
                                 input logic [31:0] cv, input logic fu);
        vec_t v;
        v = '{iv, op, qj, vj, qk, vk, cb, ct, cv, fu, 0, 0, 0, 0, 0, 0, 0};
        return v;
    endfunction

    // Drive one cycle's inputs mid-cycle, then settle before sampling.
    task automatic drive(input vec_t v);
        @(negedge clk);
        in_issue_valid   = v.iv;
        in_issue_op      = v.op;
        in_issue_qj      = v.qj;
        in_issue_vj      = v.vj;
        in_issue_qk      = v.qk;
        in_issue_vk      = v.vk;
        in_cdb_broadcast = v.cb;
        in_cdb_tag       = v.ct;
        in_cdb_val       = v.cv;
        in_fu_ready      = v.fu;
        #1;
    endtask

    task automatic chk_disp(input string name, input logic dv, input logic [3:0] op,
                            input logic [31:0] vj, input logic [31:0] vk, input logic [4:0] tag);
        chk({name, ".dv"},  32'(out_dispatch_valid), 32'(dv));
        chk({name, ".op"},  32'(out_dispatch_op),    32'(op));
        chk({name, ".vj"},  out_dispatch_vj,         vj);
        chk({name, ".vk"},  out_dispatch_vk,         vk);
        chk({name, ".tag"}, 32'(out_dispatch_tag),   32'(tag));
    endtask

    task automatic chk_issue(input string name, input logic ir, input logic [4:0] itag);
        chk({name, ".ir"},   32'(out_issue_ready), 32'(ir));
        chk({name, ".itag"}, 32'(out_issue_tag),   32'(itag));
    endtask

    vec_t vecs [18];

    initial begin
        // iv op qj vj qk vk | cb ct cv | fu || ir itag | dv op vj vk tag
        vecs[0]  = '{0, 0, I, 0,  I, 0, 0, 0,  0,       0, 1, 1, 0, 0, 0,     0,     0};
        vecs[1]  = '{1, 1, I, 3,  I, 4, 0, 0,  0,       0, 1, 1, 0, 0, 0,     0,     0};
        vecs[2]  = '{0, 0, I, 0,  I, 0, 0, 0,  0,       1, 1, 2, 1, 1, 3,     4,     1};
        vecs[3]  = '{0, 0, I, 0,  I, 0, 1, 1,  'h7,     1, 1, 2, 0, 0, 0,     0,     0};
        vecs[4]  = '{1, 2, 7, 0,  I, 5, 0, 0,  0,       1, 1, 1, 0, 0, 0,     0,     0};
        vecs[5]  = '{0, 0, I, 0,  I, 0, 0, 0,  0,       1, 1, 2, 0, 0, 0,     0,     0};
        vecs[6]  = '{0, 0, I, 0,  I, 0, 1, 7,  9,       1, 1, 2, 0, 0, 0,     0,     0};
        vecs[7]  = '{0, 0, I, 0,  I, 0, 0, 0,  0,       1, 1, 2, 1, 2, 9,     5,     1};
        vecs[8]  = '{0, 0, I, 0,  I, 0, 1, 1,  'he,     1, 1, 2, 0, 0, 0,     0,     0};
        vecs[9]  = '{1, 3, 7, 0,  I, 6, 1, 7,  'h20,    0, 1, 1, 0, 0, 0,     0,     0};
        vecs[10] = '{0, 0, I, 0,  I, 0, 0, 0,  0,       0, 1, 2, 1, 3, 'h20,  6,     1};
        vecs[11] = '{0, 0, I, 0,  I, 0, 0, 0,  0,       1, 1, 2, 1, 3, 'h20,  6,     1};
        vecs[12] = '{0, 0, I, 0,  I, 0, 1, 1,  'h26,    1, 1, 2, 0, 0, 0,     0,     0};
        vecs[13] = '{1, 4, 8, 0,  8, 0, 0, 0,  0,       1, 1, 1, 0, 0, 0,     0,     0};
        vecs[14] = '{0, 0, I, 0,  I, 0, 1, I,  'hdead,  1, 1, 2, 0, 0, 0,     0,     0};
        vecs[15] = '{0, 0, I, 0,  I, 0, 1, 8,  'h11,    1, 1, 2, 0, 0, 0,     0,     0};
        vecs[16] = '{0, 0, I, 0,  I, 0, 1, 8,  'h11,    1, 1, 2, 1, 4, 'h11,  'h11,  1};
        vecs[17] = '{0, 0, I, 0,  I, 0, 1, 1,  'h22,    1, 1, 2, 0, 0, 0,     0,     0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_issue("rst_held", 1'b1, 5'd1);
        chk_disp("rst_held", 1'b0, 0, 0, 0, 0);
        rst = 1'b0;

        foreach (vecs[n]) begin
            drive(vecs[n]);
            chk_issue($sformatf("vec%0d", n), vecs[n].e_ir, vecs[n].e_itag);
            chk_disp($sformatf("vec%0d", n), vecs[n].e_dv, vecs[n].e_op,
                     vecs[n].e_vj, vecs[n].e_vk, vecs[n].e_tag);
        end

        // Fill all four entries while dispatching behind, then reject a fifth issue.
        drive(inp(1, 5, I, 1, I, 1, 0, 0, 0, 1));
        chk_issue("fill0", 1'b1, 5'd1);
        drive(inp(1, 6, I, 2, I, 2, 0, 0, 0, 1));
        chk_issue("fill1", 1'b1, 5'd2);
        chk_disp("fill1", 1'b1, 5, 1, 1, 1);
        drive(inp(1, 7, I, 3, I, 3, 0, 0, 0, 1));
        chk_issue("fill2", 1'b1, 5'd3);
        chk_disp("fill2", 1'b1, 6, 2, 2, 2);
        drive(inp(1, 8, I, 4, I, 4, 0, 0, 0, 1));
        chk_issue("fill3", 1'b1, 5'd4);
        chk_disp("fill3", 1'b1, 7, 3, 3, 3);
        drive(inp(1, 9, I, 'h99, I, 'h99, 0, 0, 0, 0));
        chk_issue("full", 1'b0, I);
        chk_disp("full", 1'b1, 8, 4, 4, 4);
        drive(inp(0, 0, I, 0, I, 0, 1, 2, 'h4, 0));
        chk_issue("free_same_cycle", 1'b0, I);
        chk_disp("after_reject", 1'b1, 8, 4, 4, 4);
        drive(inp(0, 0, I, 0, I, 0, 0, 0, 0, 0));
        chk_issue("freed_e1", 1'b1, 5'd2);

        // Drain: complete tags 1 and 3, dispatch and complete tag 4.
        drive(inp(0, 0, I, 0, I, 0, 1, 1, 0, 0));
        drive(inp(0, 0, I, 0, I, 0, 1, 3, 0, 0));
        drive(inp(0, 0, I, 0, I, 0, 0, 0, 0, 1));
        drive(inp(0, 0, I, 0, I, 0, 1, 4, 0, 0));
        drive(inp(0, 0, I, 0, I, 0, 0, 0, 0, 0));
        chk_issue("drained", 1'b1, 5'd1);
        chk_disp("drained", 1'b0, 0, 0, 0, 0);

        // Entries 0 and 2 ready, entry 1 waiting; stall the FU then release it.
        drive(inp(1, 'ha, I, 'h10, I, 'h11, 0, 0, 0, 0));
        drive(inp(1, 'hb, 20, 0, I, 'h21, 0, 0, 0, 0));
        drive(inp(1, 'hc, I, 'h30, I, 'h31, 0, 0, 0, 0));
        for (int c = 0; c < 3; c++) begin
            drive(inp(0, 0, I, 0, I, 0, 0, 0, 0, 0));
            chk_disp($sformatf("stall%0d", c), 1'b1, 'ha, 'h10, 'h11, 1);
        end
        chk_issue("stall", 1'b1, 5'd4);
        drive(inp(0, 0, I, 0, I, 0, 0, 0, 0, 1));
        chk_disp("release_e0", 1'b1, 'ha, 'h10, 'h11, 1);
        drive(inp(0, 0, I, 0, I, 0, 0, 0, 0, 1));
        chk_disp("release_e2", 1'b1, 'hc, 'h30, 'h31, 3);
        drive(inp(0, 0, I, 0, I, 0, 1, 20, 'h55, 1));
        chk_disp("e1_waiting", 1'b0, 0, 0, 0, 0);
        drive(inp(0, 0, I, 0, I, 0, 0, 0, 0, 0));
        chk_disp("e1_woken", 1'b1, 'hb, 'h55, 'h21, 2);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
